uart_mem_loader: RTL and testbench

UART-to-memory-bus bridge that lets a host load and inspect the bf8b memory image over a serial line without the core. It receives 8N1 command frames on `rx` and executes single-byte writes or reads on the core-style word bus: 30-bit word address, 32-bit data, per-byte write enables, one-cycle registered read data. It answers each command on `tx`. It sits on the far end of the core's serial link and drives the memory bank bus while the core is held off via `busy`.

---
 rtl/uart_mem_loader.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_uart_mem_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_loader.sv
// UART command bridge: 8N1 frames on rx drive single-byte writes/reads
// on the word bus; every accepted command is answered on tx.
`timescale 1ns/1ps
module uart_mem_loader #(
    parameter int M_WIDTH      = 32,
    parameter int CLKS_PER_BIT = 16,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    output logic [M_WIDTH-3:0]   addr,
    output logic [M_WIDTH-1:0]   data_out,
    input  logic [M_WIDTH-1:0]   data_in,
    output logic [M_WIDTH/8-1:0] wes,
    output logic                 busy
);

    localparam int NL = M_WIDTH / 8;
    localparam int AW = M_WIDTH - 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TO_MAX = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW = $clog2(TO_MAX);
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_END = TW'(TO_MAX - 1);

    typedef enum logic [2:0] {
        RX_WAIT_HI, RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_e;

    typedef enum logic [2:0] {
        P_IDLE, P_ADDR, P_DATA, P_WRITE,
        P_RD_ADDR, P_RD_WAIT, P_RESP
    } p_state_e;

    // ---------------- receiver ----------------
    logic            rx_s1_q, rx_s2_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_sh_q, rx_sh_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_err_q, rx_err_d;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        case (rx_state_q)
            RX_WAIT_HI: begin
                if (rx_s2_q) rx_state_d = RX_IDLE;
            end
            RX_IDLE: begin
                if (!rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_END) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d = '0;
                    if (rx_s2_q) begin
                        rx_valid_d = 1'b1;
                        rx_byte_d  = rx_sh_q;
                        rx_state_d = RX_IDLE;
                    end else begin
                        // line still low: rearm only after it idles high
                        rx_err_d   = 1'b1;
                        rx_state_d = RX_WAIT_HI;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_WAIT_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q    <= 1'b0;
            rx_s2_q    <= 1'b0;
            rx_state_q <= RX_WAIT_HI;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
        end
    end

    // ---------------- transmitter ----------------
    logic          tx_q, tx_d;
    logic          tx_active_q, tx_active_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bits_q, tx_bits_d;
    logic [9:0]    tx_sh_q, tx_sh_d;
    logic          tx_start;
    logic          tx_done;
    logic [7:0]    resp_q, resp_d;

    assign tx_done = tx_active_q && (tx_cnt_q == BIT_END)
                     && (tx_bits_q == 4'd1);

    always_comb begin
        tx_d        = tx_q;
        tx_active_d = tx_active_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bits_d   = tx_bits_q;
        tx_sh_d     = tx_sh_q;
        if (tx_active_q) begin
            if (tx_cnt_q == BIT_END) begin
                tx_cnt_d = '0;
                if (tx_bits_q == 4'd1) begin
                    tx_active_d = 1'b0;
                    tx_d        = 1'b1;
                end else begin
                    tx_sh_d   = {1'b1, tx_sh_q[9:1]};
                    tx_d      = tx_sh_q[1];
                    tx_bits_d = tx_bits_q - 4'd1;
                end
            end else begin
                tx_cnt_d = tx_cnt_q + 1'b1;
            end
        end else if (tx_start) begin
            tx_sh_d     = {1'b1, resp_q, 1'b0};
            tx_d        = 1'b0;
            tx_bits_d   = 4'd10;
            tx_cnt_d    = '0;
            tx_active_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q        <= 1'b1;
            tx_active_q <= 1'b0;
            tx_cnt_q    <= '0;
            tx_bits_q   <= '0;
            tx_sh_q     <= '1;
        end else begin
            tx_q        <= tx_d;
            tx_active_q <= tx_active_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bits_q   <= tx_bits_d;
            tx_sh_q     <= tx_sh_d;
        end
    end

    // reset forces the line idle without waiting for the edge
    assign tx = tx_q | rst;

    // ---------------- command parser ----------------
    p_state_e         p_state_q, p_state_d;
    logic             cmd_w_q, cmd_w_d;
    logic [1:0]       acnt_q, acnt_d;
    logic [31:0]      baddr_q, baddr_d, baddr_nx;
    logic             sent_q, sent_d;
    logic [TW-1:0]    to_q, to_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [M_WIDTH-1:0] dout_q, dout_d;
    logic [NL-1:0]    wes_q, wes_d;
    logic             busy_q, busy_d;

    assign tx_start = (p_state_q == P_RESP) && !sent_q && !tx_active_q;

    always_comb begin
        p_state_d = p_state_q;
        cmd_w_d   = cmd_w_q;
        acnt_d    = acnt_q;
        baddr_d   = baddr_q;
        baddr_nx  = {rx_byte_q, baddr_q[31:8]};
        sent_d    = sent_q;
        resp_d    = resp_q;
        to_d      = to_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        wes_d     = '0;
        case (p_state_q)
            P_IDLE: begin
                if (rx_valid_q) begin
                    if (rx_byte_q == 8'h57 || rx_byte_q == 8'h52) begin
                        p_state_d = P_ADDR;
                        acnt_d    = '0;
                        cmd_w_d   = (rx_byte_q == 8'h57);
                        to_d      = '0;
                    end else begin
                        p_state_d = P_RESP;
                        resp_d    = 8'h15;
                        sent_d    = 1'b0;
                    end
                end
            end
            P_ADDR: begin
                if (rx_err_q) begin
                    p_state_d = P_IDLE;
                end else if (rx_valid_q) begin
                    baddr_d = baddr_nx;
                    acnt_d  = acnt_q + 2'd1;
                    to_d    = '0;
                    if (acnt_q == 2'd3) begin
                        if (cmd_w_q) begin
                            p_state_d = P_DATA;
                        end else begin
                            p_state_d = P_RD_ADDR;
                            addr_d    = baddr_nx[AW+1:2];
                        end
                    end
                end else if (to_q == TO_END) begin
                    p_state_d = P_IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            P_DATA: begin
                if (rx_err_q) begin
                    p_state_d = P_IDLE;
                end else if (rx_valid_q) begin
                    p_state_d = P_WRITE;
                    addr_d    = baddr_q[AW+1:2];
                    dout_d    = {NL{rx_byte_q}};
                    wes_d[baddr_q[1:0]] = 1'b1;
                end else if (to_q == TO_END) begin
                    p_state_d = P_IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            P_WRITE: begin
                p_state_d = P_RESP;
                resp_d    = 8'h06;
                sent_d    = 1'b0;
            end
            P_RD_ADDR: p_state_d = P_RD_WAIT;
            P_RD_WAIT: begin
                resp_d    = data_in[{baddr_q[1:0], 3'b000} +: 8];
                p_state_d = P_RESP;
                sent_d    = 1'b0;
            end
            P_RESP: begin
                if (tx_start) begin
                    sent_d = 1'b1;
                end else if (sent_q && tx_done) begin
                    p_state_d = P_IDLE;
                end
            end
            default: p_state_d = P_IDLE;
        endcase
        busy_d = (p_state_d != P_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_state_q <= P_IDLE;
            cmd_w_q   <= 1'b0;
            acnt_q    <= '0;
            baddr_q   <= '0;
            sent_q    <= 1'b0;
            resp_q    <= '0;
            to_q      <= '0;
            addr_q    <= '0;
            dout_q    <= '0;
            wes_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            p_state_q <= p_state_d;
            cmd_w_q   <= cmd_w_d;
            acnt_q    <= acnt_d;
            baddr_q   <= baddr_d;
            sent_q    <= sent_d;
            resp_q    <= resp_d;
            to_q      <= to_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            wes_q     <= wes_d;
            busy_q    <= busy_d;
        end
    end

    assign addr     = addr_q;
    assign data_out = dout_q;
    assign wes      = wes_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Bench for uart_mem_loader: command table plus corner sequences,
// checked against write/response scoreboards and a word memory model.
`timescale 1ns/1ps
module tb_uart_mem_loader;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic        tx;
    logic [29:0] addr;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic [3:0]  wes;
    logic        busy;

    always #5 clk = ~clk;

    uart_mem_loader #(
        .M_WIDTH(32), .CLKS_PER_BIT(CPB), .TIMEOUT_BITS(64)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx),
        .addr(addr), .data_out(data_out), .data_in(data_in),
        .wes(wes), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [29:0] a;
        logic [3:0]  w;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [5:0][7:0] b;
        int              n;
        int              resp;
        bit              wr;
        logic [29:0]     wa;
        logic [3:0]      ww;
        logic [31:0]     wd;
    } vec_t;

    wr_t  wq[$];
    int   rq[$];
    wr_t  we;
    vec_t vt[10];

    logic [31:0] mem [256];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[8'h38] <= 32'hDEADBEEF;
        end else begin
            for (int l = 0; l < 4; l++)
                if (wes[l]) mem[addr[7:0]][l*8 +: 8] <= data_out[l*8 +: 8];
        end
        data_in <= mem[addr[7:0]];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wes != 4'b0) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr 0x%0h wes %b",
                         addr, wes);
            end else begin
                we = wq.pop_front();
                chk("wr_addr", {2'b0, addr}, {2'b0, we.a});
                chk("wr_wes", {28'b0, wes}, {28'b0, we.w});
                chk("wr_data", data_out, we.d);
            end
        end
    end

    initial begin
        logic [7:0] b;
        logic       stp;
        int         ev;
        forever begin
            @(negedge tx);
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            stp = tx;
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tx: byte 0x%0h", b);
            end else begin
                ev = rq.pop_front();
                if (ev >= 0) begin
                    chk("tx_byte", {24'b0, b}, ev);
                    chk("tx_stop", {31'b0, stp}, 32'd1);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = !bad_stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic wait_done();
        int k = 0;
        while ((rq.size() != 0 || busy) && k < 60 * CPB) begin
            @(negedge clk);
            k++;
        end
        chk("resp_pending", rq.size(), 32'd0);
        chk("busy_end", {31'b0, busy}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        if (v.wr) wq.push_back('{a: v.wa, w: v.ww, d: v.wd});
        rq.push_back(v.resp);
        for (int i = 0; i < v.n; i++) begin
            send_byte(v.b[i], 1'b0);
            if (i == 0) begin
                @(negedge clk);
                chk("busy_cmd", {31'b0, busy}, 32'd1);
            end
        end
        wait_done();
    endtask

    initial begin
        int k;
        vt[0] = '{b: {8'h5A, 8'h00, 8'h00, 8'h00, 8'hE1, 8'h57}, n: 6,
                  resp: 8'h06, wr: 1, wa: 30'h38, ww: 4'b0010,
                  wd: 32'h5A5A5A5A};
        vt[1] = '{b: {8'h00, 8'h00, 8'h00, 8'h00, 8'hE3, 8'h52}, n: 5,
                  resp: 8'hDE, wr: 0, wa: 30'h0, ww: 4'b0, wd: 32'h0};
        vt[2] = '{b: {8'h00, 8'h00, 8'h00, 8'h00, 8'hE1, 8'h52}, n: 5,
                  resp: 8'h5A, wr: 0, wa: 30'h0, ww: 4'b0, wd: 32'h0};
        vt[3] = '{b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h41}, n: 1,
                  resp: 8'h15, wr: 0, wa: 30'h0, ww: 4'b0, wd: 32'h0};
        vt[4] = '{b: {8'hC3, 8'h00, 8'h00, 8'h00, 8'h10, 8'h57}, n: 6,
                  resp: 8'h06, wr: 1, wa: 30'h4, ww: 4'b0001,
                  wd: 32'hC3C3C3C3};
        vt[5] = '{b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h52}, n: 5,
                  resp: 8'hC3, wr: 0, wa: 30'h0, ww: 4'b0, wd: 32'h0};
        vt[6] = '{b: {8'h3C, 8'h80, 8'h00, 8'h01, 8'h07, 8'h57}, n: 6,
                  resp: 8'h06, wr: 1, wa: 30'h20000041, ww: 4'b1000,
                  wd: 32'h3C3C3C3C};
        vt[7] = '{b: {8'h00, 8'h80, 8'h00, 8'h01, 8'h07, 8'h52}, n: 5,
                  resp: 8'h3C, wr: 0, wa: 30'h0, ww: 4'b0, wd: 32'h0};
        vt[8] = '{b: {8'hA5, 8'h00, 8'h00, 8'h00, 8'h03, 8'h57}, n: 6,
                  resp: 8'h06, wr: 1, wa: 30'h0, ww: 4'b1000,
                  wd: 32'hA5A5A5A5};
        vt[9] = '{b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h52}, n: 5,
                  resp: 8'hA5, wr: 0, wa: 30'h0, ww: 4'b0, wd: 32'h0};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_addr", {2'b0, addr}, 32'd0);
        chk("rst_dout", data_out, 32'd0);
        chk("rst_wes", {28'b0, wes}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vt[i]);

        // stop bit of the second address byte held low
        send_byte(8'h52, 1'b0);
        @(negedge clk);
        chk("fe_busy_cmd", {31'b0, busy}, 32'd1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b1);
        repeat (CPB) @(negedge clk);
        chk("fe_busy_abort", {31'b0, busy}, 32'd0);
        repeat (20 * CPB) @(negedge clk);

        // short low pulse must not start a frame
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        chk("glitch_busy", {31'b0, busy}, 32'd0);

        // inter-byte timeout
        send_byte(8'h57, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        repeat (60 * CPB) @(negedge clk);
        chk("to_busy_held", {31'b0, busy}, 32'd1);
        k = 0;
        while (busy && k < 8 * CPB) begin
            @(negedge clk);
            k++;
        end
        chk("to_busy_fall", {31'b0, busy}, 32'd0);
        run_vec(vt[1]);

        // reset during the ACK transmission
        wq.push_back('{a: 30'h4, w: 4'b0001, d: 32'h77777777});
        rq.push_back(-1);
        send_byte(8'h57, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h77, 1'b0);
        k = 0;
        while (tx && k < 4 * CPB) begin
            @(negedge clk);
            k++;
        end
        chk("ack_started", {31'b0, tx}, 32'd0);
        repeat (3 * CPB) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", {31'b0, tx}, 32'd1);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_addr", {2'b0, addr}, 32'd0);
        chk("mid_rst_dout", data_out, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_tx", {31'b0, tx}, 32'd1);
        repeat (10 * CPB) @(negedge clk);
        run_vec(vt[8]);
        run_vec(vt[9]);

        repeat (4 * CPB) @(negedge clk);
        chk("wq_empty", wq.size(), 32'd0);
        chk("rq_empty", rq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
